// File: rtl/cnn_input_loader.sv
// Front-end loader for the CNN accelerator: captures 3x3 weights and one frame from the host,
// replays the frame as a gap-free pixel stream, and counts pooled results until the frame is done.
module cnn_input_loader #(
  parameter int N     = 16,
  parameter int IMG_N = 6,
  parameter int K     = 3,
  parameter int P     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] k00,
  output logic [N-1:0] k01,
  output logic [N-1:0] k02,
  output logic [N-1:0] k10,
  output logic [N-1:0] k11,
  output logic [N-1:0] k12,
  output logic [N-1:0] k20,
  output logic [N-1:0] k21,
  output logic [N-1:0] k22,
  output logic [N-1:0] pixel_out,
  output logic         en_out,
  input  logic         pool_valid,
  output logic         busy,
  output logic         done
);

  localparam int KW       = K * K;
  localparam int FRAME    = IMG_N * IMG_N;
  localparam int WORDS    = KW + FRAME;
  localparam int POOL_CNT = ((IMG_N - K + 1) / P) * ((IMG_N - K + 1) / P);
  localparam int WCW      = $clog2(WORDS + 1);
  localparam int RCW      = $clog2(FRAME + 1);
  localparam int PCW      = $clog2(POOL_CNT + 1);
  localparam int AW       = $clog2(FRAME);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic [PCW-1:0] pool_cnt_q, pool_cnt_d;
  logic [N-1:0]   k_q [KW];
  logic [N-1:0]   k_d [KW];
  logic           en_out_q, en_out_d;
  logic           done_q, done_d;
  logic [N-1:0]   pixel_out_q;
  logic [N-1:0]   mem_q [FRAME];
  logic           wr_en;
  logic           rd_en;
  logic [AW-1:0]  wr_addr;

  assign wr_addr = AW'(word_cnt_q - WCW'(KW));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pool_cnt_d = pool_cnt_q;
    k_d        = k_q;
    en_out_d   = 1'b0;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    // Pooled results can arrive while the stream is still running.
    if ((state_q == STREAM || state_q == DRAIN) && pool_valid &&
        pool_cnt_q != PCW'(POOL_CNT)) begin
      pool_cnt_d = pool_cnt_q + PCW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          word_cnt_d = '0;
          rd_cnt_d   = '0;
          pool_cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          word_cnt_d = word_cnt_q + WCW'(1);
          if (word_cnt_q < WCW'(KW)) begin
            for (int i = 0; i < KW; i++) begin
              if (word_cnt_q == WCW'(i)) k_d[i] = in_data;
            end
          end else begin
            wr_en = 1'b1;
          end
          if (word_cnt_q == WCW'(WORDS - 1)) begin
            state_d  = STREAM;
            rd_cnt_d = '0;
          end
        end
      end
      STREAM: begin
        en_out_d = 1'b1;
        rd_en    = 1'b1;
        if (rd_cnt_q == RCW'(FRAME - 1)) state_d = DRAIN;
        else                             rd_cnt_d = rd_cnt_q + RCW'(1);
      end
      DRAIN: begin
        if (pool_cnt_d == PCW'(POOL_CNT)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      pool_cnt_q  <= '0;
      k_q         <= '{default: '0};
      en_out_q    <= 1'b0;
      done_q      <= 1'b0;
      pixel_out_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pool_cnt_q <= pool_cnt_d;
      k_q        <= k_d;
      en_out_q   <= en_out_d;
      done_q     <= done_d;
      // pixel_out is the registered read port of the frame buffer
      if (rd_en) pixel_out_q <= mem_q[AW'(rd_cnt_q)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= in_data;
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign en_out    = en_out_q;
  assign done      = done_q;
  assign pixel_out = pixel_out_q;
  assign k00 = k_q[0];
  assign k01 = k_q[1];
  assign k02 = k_q[2];
  assign k10 = k_q[3];
  assign k11 = k_q[4];
  assign k12 = k_q[5];
  assign k20 = k_q[6];
  assign k21 = k_q[7];
  assign k22 = k_q[8];

endmodule
